memreq_arbiter: RTL and testbench
=================================

Name: memreq_arbiter

Overview:
- Shares one memreq command/response byte-stream port, in the bus clock domain, between two requesters (e.g. SPI and USB front-ends).
- Grants whole request packets round-robin and forwards them to memreq.s_*.
- Steers each memreq response packet (m_*) back to the requester that issued the request, using an in-order tag FIFO; memreq completes requests in order.

Parameters:
TAG_DEPTH, 4, maximum outstanding response-generating requests (power of 2, >=2)
TAG_BITS, 2, log2(TAG_DEPTH)

Ports:
bclk  in  1  bus clock
rst  in  1  synchronous active-high reset
s0_tvalid/s0_tready/s0_tkeep/s0_tlast  in/out/in/in  1  requester 0 command stream
s0_tdata  in  8  requester 0 command byte
s1_tvalid/s1_tready/s1_tkeep/s1_tlast  in/out/in/in  1  requester 1 command stream
s1_tdata  in  8  requester 1 command byte
m_tvalid/m_tready/m_tkeep/m_tlast  out/in/out/out  1  to memreq s_* port
m_tdata  out  8  forwarded byte
r_tvalid/r_tready/r_tkeep/r_tlast  in/out/in/in  1  from memreq m_* port
r_tdata  in  8  response byte
q0_tvalid/q0_tready/q0_tkeep/q0_tlast  out/in/out/out  1  responses to requester 0
q0_tdata  out  8
q1_tvalid/q1_tready/q1_tkeep/q1_tlast  out/in/out/out  1  responses to requester 1
q1_tdata  out  8
outstanding_o  out  TAG_BITS+1  tag FIFO occupancy
busy_o  out  1  request packet in flight or outstanding_o != 0

Behaviour:
- Reset: rst is synchronous, active-high; clock bclk.
  - Request FSM -> IDLE, last_grant=1 (so s0 wins first), tag FIFO empty.
  - All tvalid/tready outputs 0, outstanding_o=0, busy_o=0.
- Request FSM: IDLE, FWD.
  - IDLE: no s*_tready. If outstanding_o==TAG_DEPTH, stay.
  - Else if exactly one s*_tvalid is high, grant it. If both are high, grant the one != last_grant.
  - Register sel and last_grant; next state FWD. Grant latency: 1 cycle after tvalid is seen in IDLE.
- FWD: combinational pass-through of the selected stream.
  - m_tvalid/m_tkeep/m_tlast/m_tdata = s[sel]; s[sel]_tready = m_tready; the other tready = 0.
  - First beat of a packet (tracked by a first flag): if tdata != 8'h00 (CMD_NOP), push sel into the tag FIFO on transfer.
  - Beat with tlast && handshake: return to IDLE.
  - Packets are never interleaved, whatever the backpressure.
- Tag FIFO:
  - Push on a first-beat transfer of a non-NOP packet. Pop on r_tvalid && r_tready && r_tlast.
  - Simultaneous push and pop: occupancy unchanged.
  - Pointers wrap modulo TAG_DEPTH.
  - The full check in IDLE guarantees no push while full.
- Response routing, combinational:
  - FIFO empty: r_tready=0 and both q*_tvalid=0. Orphan responses stall; no data is dropped.
  - FIFO non-empty, head tag t: q[t]_* mirror r_*, r_tready = q[t]_tready, q[!t]_tvalid = 0.
  - Tag advances only after the last beat of the response packet.
- Request and response paths are independent. Forwarding a new request while a response streams out is allowed.
- Reset mid-packet: the packet is abandoned, with no recovery. The upstream requester re-sends.

Test Plan:
- s0 sends STORE {01,08,F0,80,20,A0} + 8 data bytes, tlast on byte 14 -> 14 bytes on m_* in order with tlast on the 14th; outstanding_o=1; response {02,...} on r_* appears only on q0 and outstanding_o returns to 0.
- s0 and s1 both assert tvalid in the same cycle from reset -> s0 packet forwarded whole first, then s1; with both held continuously the grants alternate 0,1,0,1.
- s0 STORE, then s1 FETCH {80,08,F0,80,20,50}; memreq returns WDONE then RDATA -> WDONE on q0, RDATA (with its data) on q1; q1_tvalid stays 0 during the WDONE packet.
- s1 sends a 1-byte NOP (00, tlast) -> forwarded, outstanding_o stays 0. An r_tvalid with an empty FIFO -> r_tready held 0 for 20 cycles.
- TAG_DEPTH=4: four FETCHes issued with no responses -> a fifth s0_tvalid gets no s0_tready. One response completes -> the fifth packet is granted on the next IDLE cycle.
- m_tready toggled randomly and q0_tready held low mid-response -> no byte lost or duplicated, order preserved, the r_* stall propagates, and outstanding_o stays correct.

Source files
------------

// File: rtl/memreq_arbiter_if.sv
// Byte-wide valid/ready stream used on every memreq_arbiter port.
// master drives the payload, slave drives tready.
interface memreq_arbiter_if;
  logic       tvalid;
  logic       tready;
  logic       tkeep;
  logic       tlast;
  logic [7:0] tdata;

  modport master (output tvalid, output tkeep, output tlast, output tdata, input  tready);
  modport slave  (input  tvalid, input  tkeep, input  tlast, input  tdata, output tready);
endinterface

// File: rtl/memreq_arbiter.sv
// Round-robin packet arbiter sharing one memreq command port between two requesters.
// Responses are steered back to the issuer through an in-order tag FIFO.
module memreq_arbiter #(
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned TAG_BITS  = 2
) (
  input  logic                bclk,
  input  logic                rst,
  memreq_arbiter_if.slave     s0,
  memreq_arbiter_if.slave     s1,
  memreq_arbiter_if.master    m,
  memreq_arbiter_if.slave     r,
  memreq_arbiter_if.master    q0,
  memreq_arbiter_if.master    q1,
  output logic [TAG_BITS:0]   outstanding_o,
  output logic                busy_o
);

  localparam int unsigned CNT_W   = TAG_BITS + 1;
  localparam logic [7:0]  CMD_NOP = 8'h00;

  typedef enum logic {IDLE, FWD} state_e;

  state_e               state_q;
  logic                 sel_q;
  logic                 last_grant_q;
  logic                 first_q;
  logic [TAG_BITS-1:0]  wr_ptr_q;
  logic [TAG_BITS-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 tag_q [TAG_DEPTH];

  logic                 fwd;
  logic                 sel_valid;
  logic                 sel_keep;
  logic                 sel_last;
  logic [7:0]           sel_data;
  logic                 req_xfer;
  logic                 grant_sel;
  logic                 fifo_full;
  logic                 tags_avail;
  logic                 head_tag;
  logic                 rsp_ready;
  logic                 push;
  logic                 pop;

  // Request path: pass the granted stream straight through while forwarding.
  always_comb begin
    fwd       = (state_q == FWD);
    sel_valid = sel_q ? s1.tvalid : s0.tvalid;
    sel_keep  = sel_q ? s1.tkeep  : s0.tkeep;
    sel_last  = sel_q ? s1.tlast  : s0.tlast;
    sel_data  = sel_q ? s1.tdata  : s0.tdata;

    m.tvalid  = fwd & sel_valid;
    m.tkeep   = sel_keep;
    m.tlast   = sel_last;
    m.tdata   = sel_data;
    s0.tready = fwd & ~sel_q & m.tready;
    s1.tready = fwd &  sel_q & m.tready;

    req_xfer  = fwd & sel_valid & m.tready;
    push      = req_xfer & first_q & (sel_data != CMD_NOP);
    grant_sel = (s0.tvalid & s1.tvalid) ? ~last_grant_q : s1.tvalid;
    fifo_full = (count_q == CNT_W'(TAG_DEPTH));
  end

  // Response path: the FIFO head names the requester owning the current response.
  always_comb begin
    tags_avail = (count_q != '0);
    head_tag   = tag_q[rd_ptr_q];
    rsp_ready  = tags_avail & (head_tag ? q1.tready : q0.tready);

    q0.tvalid  = tags_avail & ~head_tag & r.tvalid;
    q0.tkeep   = r.tkeep;
    q0.tlast   = r.tlast;
    q0.tdata   = r.tdata;
    q1.tvalid  = tags_avail &  head_tag & r.tvalid;
    q1.tkeep   = r.tkeep;
    q1.tlast   = r.tlast;
    q1.tdata   = r.tdata;
    r.tready   = rsp_ready;

    pop        = r.tvalid & rsp_ready & r.tlast;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Request FSM and tag FIFO bookkeeping.
  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      first_q      <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + TAG_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + TAG_BITS'(1);

      case (state_q)
        IDLE: begin
          if (!fifo_full && (s0.tvalid || s1.tvalid)) begin
            sel_q        <= grant_sel;
            last_grant_q <= grant_sel;
            first_q      <= 1'b1;
            state_q      <= FWD;
          end
        end
        FWD: begin
          if (req_xfer) begin
            first_q <= 1'b0;
            if (sel_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read once written.
  always_ff @(posedge bclk) begin
    if (push) tag_q[wr_ptr_q] <= sel_q;
  end

  assign outstanding_o = count_q;
  assign busy_o        = fwd | (count_q != '0);

endmodule

// File: tb/tb_memreq_arbiter.sv
// Randomized bench for memreq_arbiter with a packet/queue-level reference model
// and a few hand-computed directed expectations.
module tb_memreq_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0] STORE_HDR [6] = '{8'h01, 8'h08, 8'hF0, 8'h80, 8'h20, 8'hA0};
  localparam logic [7:0] FETCH_HDR [6] = '{8'h80, 8'h08, 8'hF0, 8'h80, 8'h20, 8'h50};

  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } beat_t;

  logic       bclk = 1'b0;
  logic       rst;
  logic [2:0] outstanding_o;
  logic       busy_o;

  memreq_arbiter_if s0_if ();
  memreq_arbiter_if s1_if ();
  memreq_arbiter_if m_if ();
  memreq_arbiter_if r_if ();
  memreq_arbiter_if q0_if ();
  memreq_arbiter_if q1_if ();

  memreq_arbiter #(.TAG_DEPTH(DEPTH), .TAG_BITS(2)) dut (
    .bclk          (bclk),
    .rst           (rst),
    .s0            (s0_if),
    .s1            (s1_if),
    .m             (m_if),
    .r             (r_if),
    .q0            (q0_if),
    .q1            (q1_if),
    .outstanding_o (outstanding_o),
    .busy_o        (busy_o)
  );

  always #5 bclk = ~bclk;

  int checks = 0;
  int errors = 0;

  beat_t      sq0[$], sq1[$], rq[$], eq0[$], eq1[$], mlog[$];
  logic [7:0] qlog0[$], qlog1[$];
  int         glog[$], pend_src[$];
  logic [7:0] pend_cmd[$];
  int         src_pct = 100, m_pct = 100, r_pct = 100, q0_pct = 100, q1_pct = 100;
  bit         resp_auto = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_beat(int k, logic [7:0] d, logic l);
    if (k == 0) sq0.push_back({l, d});
    else        sq1.push_back({l, d});
  endfunction

  function automatic void send_store(int k);
    for (int i = 0; i < 14; i++)
      push_beat(k, (i < 6) ? STORE_HDR[i] : 8'(8'hD0 + i), i == 13);
  endfunction

  function automatic void send_fetch(int k);
    for (int i = 0; i < 6; i++) push_beat(k, FETCH_HDR[i], i == 5);
  endfunction

  function automatic void send_rand(int k);
    int         len = int'($urandom_range(1, 6));
    int         c   = int'($urandom_range(0, 2));
    logic [7:0] cmd = (c == 0) ? 8'h00 : (c == 1) ? 8'h01 : 8'h80;
    for (int i = 0; i < len; i++)
      push_beat(k, (i == 0) ? cmd : 8'($urandom), i == len - 1);
  endfunction

  // memreq side: STORE answers WDONE (02), FETCH answers RDATA (81 + 4 bytes).
  function automatic void make_resp();
    int         s   = pend_src.pop_front();
    logic [7:0] c   = pend_cmd.pop_front();
    int         n   = (c == 8'h80) ? 5 : 1;
    beat_t      b;
    for (int i = 0; i < n; i++) begin
      b.d = (i == 0) ? ((n == 5) ? 8'h81 : 8'h02) : 8'($urandom);
      b.l = (i == n - 1);
      rq.push_back(b);
      if (s == 0) eq0.push_back(b);
      else        eq1.push_back(b);
    end
  endfunction

  // Stimulus: drives all bench-owned inputs just after each rising edge.
  initial begin : drv
    bit h0, h1, hr, v0, v1, vr;
    s0_if.tvalid = 0; s0_if.tkeep = 1; s0_if.tlast = 0; s0_if.tdata = 0;
    s1_if.tvalid = 0; s1_if.tkeep = 1; s1_if.tlast = 0; s1_if.tdata = 0;
    r_if.tvalid  = 0; r_if.tkeep  = 1; r_if.tlast  = 0; r_if.tdata  = 0;
    m_if.tready  = 0; q0_if.tready = 0; q1_if.tready = 0;
    forever begin
      @(negedge bclk);
      h0 = s0_if.tvalid && s0_if.tready;
      h1 = s1_if.tvalid && s1_if.tready;
      hr = r_if.tvalid && r_if.tready;
      @(posedge bclk);
      #1;
      if (h0 && sq0.size() > 0) void'(sq0.pop_front());
      if (h1 && sq1.size() > 0) void'(sq1.pop_front());
      if (hr && rq.size() > 0)  void'(rq.pop_front());
      if (resp_auto) while (pend_src.size() > 0) make_resp();
      v0 = sq0.size() > 0 && ((s0_if.tvalid && !h0) || $urandom_range(0, 99) < src_pct);
      v1 = sq1.size() > 0 && ((s1_if.tvalid && !h1) || $urandom_range(0, 99) < src_pct);
      vr = rq.size() > 0  && ((r_if.tvalid && !hr)  || $urandom_range(0, 99) < r_pct);
      s0_if.tvalid = v0;
      if (sq0.size() > 0) begin s0_if.tdata = sq0[0].d; s0_if.tlast = sq0[0].l; end
      s1_if.tvalid = v1;
      if (sq1.size() > 0) begin s1_if.tdata = sq1[0].d; s1_if.tlast = sq1[0].l; end
      r_if.tvalid = vr;
      if (rq.size() > 0) begin r_if.tdata = rq[0].d; r_if.tlast = rq[0].l; end
      m_if.tready  = $urandom_range(0, 99) < m_pct;
      q0_if.tready = $urandom_range(0, 99) < q0_pct;
      q1_if.tready = $urandom_range(0, 99) < q1_pct;
    end
  end

  // Reference model and per-cycle compare, evaluated on the falling edge.
  initial begin : cmp
    bit         in_pkt, first, sel, lastg, ne, head, sv, sl, e_mv, e_rr, e_q0, e_q1, pop, push;
    logic [7:0] sd, pfirst;
    int         tagq[$];
    in_pkt = 0; first = 0; sel = 0; lastg = 1; pfirst = 0;
    forever begin
      @(negedge bclk);
      if (rst) begin
        in_pkt = 0; lastg = 1; tagq.delete();
      end else begin
        ne   = tagq.size() > 0;
        head = ne ? tagq[0][0] : 1'b0;
        sv   = sel ? s1_if.tvalid : s0_if.tvalid;
        sd   = sel ? s1_if.tdata  : s0_if.tdata;
        sl   = sel ? s1_if.tlast  : s0_if.tlast;
        e_mv = in_pkt && sv;
        e_rr = ne && (head ? q1_if.tready : q0_if.tready);
        e_q0 = ne && !head && r_if.tvalid;
        e_q1 = ne &&  head && r_if.tvalid;

        chk("m_tvalid", m_if.tvalid, e_mv);
        if (e_mv) begin
          chk("m_tdata", m_if.tdata, sd);
          chk("m_tlast", m_if.tlast, sl);
          chk("m_tkeep", m_if.tkeep, 1);
        end
        chk("s0_tready", s0_if.tready, in_pkt && !sel && m_if.tready);
        chk("s1_tready", s1_if.tready, in_pkt &&  sel && m_if.tready);
        chk("r_tready", r_if.tready, e_rr);
        chk("q0_tvalid", q0_if.tvalid, e_q0);
        chk("q1_tvalid", q1_if.tvalid, e_q1);
        if (e_q0) chk("q0_beat", {q0_if.tkeep, q0_if.tlast, q0_if.tdata}, {r_if.tkeep, r_if.tlast, r_if.tdata});
        if (e_q1) chk("q1_beat", {q1_if.tkeep, q1_if.tlast, q1_if.tdata}, {r_if.tkeep, r_if.tlast, r_if.tdata});
        chk("outstanding_o", outstanding_o, tagq.size());
        chk("busy_o", busy_o, in_pkt || ne);

        // End-to-end: each response beat must be the next one owed to that requester.
        if (q0_if.tvalid && q0_if.tready) begin
          qlog0.push_back(q0_if.tdata);
          chk("q0_owed", eq0.size() != 0, 1);
          if (eq0.size() != 0) chk("q0_data", {q0_if.tlast, q0_if.tdata}, eq0.pop_front());
        end
        if (q1_if.tvalid && q1_if.tready) begin
          qlog1.push_back(q1_if.tdata);
          chk("q1_owed", eq1.size() != 0, 1);
          if (eq1.size() != 0) chk("q1_data", {q1_if.tlast, q1_if.tdata}, eq1.pop_front());
        end

        pop  = r_if.tvalid && e_rr && r_if.tlast;
        push = 0;
        if (in_pkt) begin
          if (e_mv && m_if.tready) begin
            mlog.push_back({sl, sd});
            if (first) begin
              pfirst = sd;
              glog.push_back(int'(sel));
              push = (sd != 8'h00);
            end
            first = 0;
            if (sl) begin
              in_pkt = 0;
              if (pfirst != 8'h00) begin
                pend_src.push_back(int'(sel));
                pend_cmd.push_back(pfirst);
              end
            end
          end
        end else if (tagq.size() < DEPTH && (s0_if.tvalid || s1_if.tvalid)) begin
          sel    = (s0_if.tvalid && s1_if.tvalid) ? !lastg : s1_if.tvalid;
          lastg  = sel;
          in_pkt = 1;
          first  = 1;
        end
        if (pop)  void'(tagq.pop_front());
        if (push) tagq.push_back(int'(sel));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge bclk);
    #2;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 5000; i++) begin
      if (sq0.size() == 0 && sq1.size() == 0 && rq.size() == 0 && pend_src.size() == 0 &&
          eq0.size() == 0 && eq1.size() == 0 && !busy_o) break;
      cyc(1);
    end
    chk(nm, i < 5000, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cnt, base;
    rst = 1;
    cyc(3);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_r_tready", r_if.tready, 0);
    rst = 0;

    // Single STORE from s0, response routed to q0.
    resp_auto = 0;
    send_store(0);
    for (int i = 0; i < 200 && mlog.size() < 14; i++) cyc(1);
    chk("store_len", mlog.size(), 14);
    if (mlog.size() == 14)
      for (int i = 0; i < 14; i++)
        chk("store_byte", mlog[i], {i == 13, (i < 6) ? STORE_HDR[i] : 8'(8'hD0 + i)});
    cyc(2);
    chk("store_outstanding", outstanding_o, 1);
    make_resp();
    for (int i = 0; i < 100 && qlog0.size() < 1; i++) cyc(1);
    chk("wdone_q0_count", qlog0.size(), 1);
    if (qlog0.size() > 0) chk("wdone_q0_byte", qlog0[0], 8'h02);
    chk("wdone_q1_count", qlog1.size(), 0);
    cyc(2);
    chk("wdone_outstanding", outstanding_o, 0);

    // 1-byte NOP from s1, then an orphan response with nothing outstanding.
    send_rand(1);
    sq1.delete();
    push_beat(1, 8'h00, 1'b1);
    for (int i = 0; i < 100 && mlog.size() < 15; i++) cyc(1);
    cyc(3);
    chk("nop_forwarded", mlog.size(), 15);
    chk("nop_outstanding", outstanding_o, 0);
    rq.push_back({1'b1, 8'h55});
    cnt = 0;
    repeat (20) begin cyc(1); cnt += int'(r_if.tready); end
    chk("orphan_r_tready", cnt, 0);
    rq.delete();
    cyc(3);

    // Contention from reset: grants alternate 0,1,0,1.
    rst = 1; cyc(2); rst = 0;
    glog.delete();
    resp_auto = 1;
    send_fetch(0); send_store(0); send_fetch(1); send_store(1);
    for (int i = 0; i < 500 && glog.size() < 4; i++) cyc(1);
    chk("rr_grants", glog.size(), 4);
    if (glog.size() >= 4) for (int i = 0; i < 4; i++) chk("rr_order", glog[i], i % 2);
    wait_idle("rr_idle");

    // STORE on s0 then FETCH on s1; WDONE to q0, RDATA to q1.
    resp_auto = 0;
    qlog0.delete(); qlog1.delete();
    send_store(0); send_fetch(1);
    for (int i = 0; i < 300 && pend_src.size() < 2; i++) cyc(1);
    chk("mixed_pending", pend_src.size(), 2);
    if (pend_src.size() == 2) begin
      chk("mixed_first_src", pend_src[0], 0);
      make_resp(); make_resp();
    end
    wait_idle("mixed_idle");
    chk("mixed_q0_len", qlog0.size(), 1);
    chk("mixed_q1_len", qlog1.size(), 5);
    if (qlog1.size() > 0) chk("mixed_q1_code", qlog1[0], 8'h81);

    // Tag FIFO full: the fifth request waits for one response.
    for (int k = 0; k < 4; k++) send_fetch(1);
    for (int i = 0; i < 500 && pend_src.size() < 4; i++) cyc(1);
    chk("full_outstanding", outstanding_o, 4);
    send_fetch(0);
    cnt = 0;
    repeat (10) begin cyc(1); cnt += int'(s0_if.tready); end
    chk("full_no_tready", cnt, 0);
    chk("full_s0_waiting", s0_if.tvalid, 1);
    base = mlog.size();
    make_resp();
    for (int i = 0; i < 100 && mlog.size() < base + 6; i++) cyc(1);
    chk("fifth_granted", mlog.size(), base + 6);
    resp_auto = 1;
    wait_idle("full_idle");

    // Random traffic with backpressure on every stream.
    src_pct = 70; m_pct = 50; r_pct = 80;
    for (int p = 0; p < 60; p++) send_rand(int'($urandom_range(0, 1)));
    for (int i = 0; i < 20000; i++) begin
      if (i % 50 == 0) begin
        q0_pct = (i % 150 == 0) ? 0 : int'($urandom_range(20, 100));
        q1_pct = int'($urandom_range(20, 100));
      end
      if (sq0.size() == 0 && sq1.size() == 0 && rq.size() == 0 && pend_src.size() == 0 &&
          eq0.size() == 0 && eq1.size() == 0 && !busy_o) break;
      cyc(1);
    end
    q0_pct = 100;
    wait_idle("random_idle");
    chk("random_outstanding", outstanding_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
